// File: rtl/fir_mac_serial.sv
// ---------------------------------------------------------------------------
// fir_mac_serial
//   N-tap signed FIR filter built around a single multiply-accumulate unit.
//   One sample is accepted, then TAPS MAC cycles walk the delay line and the
//   coefficient bank. The last cycle registers the result and pulses
//   out_valid. Coefficients can be rewritten at run time while idle.
//
//   Optional build macro:
//     FIR_SAT_EN - saturate y_out to the OUT_W signed range instead of wrapping.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     x_in holds a sample
//   in_ready     high while idle (combinational from state)
//   x_in         signed input sample, DATA_W bits
//   coef_we      coefficient write strobe
//   coef_addr    tap index to write
//   coef_wdata   signed coefficient value, COEF_W bits
//   coef_err     one-cycle pulse after a dropped write (busy or bad index)
//   out_valid    one-cycle pulse when y_out carries a new result
//   y_out        signed filter output, OUT_W bits, held between results
// ---------------------------------------------------------------------------
module fir_mac_serial #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int TAPS   = 4,
   parameter int OUT_W  = 16,
   parameter int SHIFT  = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] x_in,
   input  logic                     coef_we,
   input  logic [$clog2(TAPS)-1:0]  coef_addr,
   input  logic signed [COEF_W-1:0] coef_wdata,
   output logic                     coef_err,
   output logic                     out_valid,
   output logic signed [OUT_W-1:0]  y_out
);

   localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
   localparam int AW    = $clog2(TAPS);

   typedef enum logic {IDLE, MAC} state_t;

   state_t state, state_nxt;

   logic signed [DATA_W-1:0] xline [TAPS];
   logic signed [COEF_W-1:0] coef  [TAPS];
   logic [AW-1:0]            k;
   logic signed [ACC_W-1:0]  acc, prod, sum, s;
   logic signed [OUT_W-1:0]  y_nxt;
   logic                     accept, wr_ok, last;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;
   // Widen the index by one bit so TAPS itself is representable.
   assign wr_ok    = coef_we && (state == IDLE) &&
                     ({1'b0, coef_addr} < (AW+1)'(TAPS));
   assign last     = (k == AW'(TAPS-1));

   // Full-precision product; ACC_W leaves headroom for TAPS worst-case terms.
   assign prod = ACC_W'(coef[k]) * ACC_W'(xline[k]);
   assign sum  = acc + prod;
   assign s    = sum >>> SHIFT;

`ifdef FIR_SAT_EN
   localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
   localparam logic signed [EXT_W-1:0] YMAX = EXT_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
   localparam logic signed [EXT_W-1:0] YMIN = ~YMAX;

   logic signed [EXT_W-1:0] s_ext;

   always_comb begin
      s_ext = EXT_W'(s);
      y_nxt = OUT_W'(s_ext);
      if (s_ext > YMAX)      y_nxt = OUT_W'(YMAX);
      else if (s_ext < YMIN) y_nxt = OUT_W'(YMIN);
   end
`else
   // Two's-complement wrap: keep the low OUT_W bits.
   assign y_nxt = OUT_W'(s);
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = MAC;
         MAC:  if (last)   state_nxt = IDLE;
         default:          state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TAPS; i++) begin
            xline[i] <= '0;
            coef[i]  <= COEF_W'(i + 1);
         end
         acc       <= '0;
         k         <= '0;
         y_out     <= '0;
         out_valid <= 1'b0;
         coef_err  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         coef_err  <= coef_we && !wr_ok;
         // A write in the accepting cycle lands before the first MAC read.
         if (wr_ok) coef[coef_addr] <= coef_wdata;
         if (accept) begin
            for (int i = TAPS-1; i > 0; i--) xline[i] <= xline[i-1];
            xline[0] <= x_in;
            acc      <= '0;
            k        <= '0;
         end
         if (state == MAC) begin
            acc <= sum;
            k   <= k + 1'b1;
            if (last) begin
               y_out     <= y_nxt;
               out_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fir_mac_serial.sv
module tb_fir_mac_serial;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, in_valid, coef_we;
   logic signed [7:0] x_in, coef_wdata;
   logic [2:0]        coef_addr;

   // Unit A: defaults (4 taps, 16-bit out). Unit B: 5 taps, 8-bit out.
   logic               rdy_a, err_a, ov_a;
   logic signed [15:0] y_a;
   logic               rdy_b, err_b, ov_b;
   logic signed [7:0]  y_b;

   int ncmp = 0, nfail = 0;

   typedef struct {
      logic signed [7:0] x;
      int                y_wrap;
      int                y_sat;
   } vec_t;

   vec_t va[9];
   vec_t vb[10];

   fir_mac_serial u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .x_in(x_in),
      .coef_we(coef_we), .coef_addr(coef_addr[1:0]), .coef_wdata(coef_wdata),
      .coef_err(err_a), .out_valid(ov_a), .y_out(y_a));

   fir_mac_serial #(.TAPS(5), .OUT_W(8)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .x_in(x_in),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .coef_err(err_b), .out_valid(ov_b), .y_out(y_b));

   function automatic logic rdy(input bit sel);
      return sel ? rdy_b : rdy_a;
   endfunction
   function automatic logic ov(input bit sel);
      return sel ? ov_b : ov_a;
   endfunction
   function automatic int yv(input bit sel);
      return sel ? int'(y_b) : int'(y_a);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wr(input int a, input int d);
      coef_we = 1'b1; coef_addr = 3'(a); coef_wdata = 8'(d);
      @(posedge clk); #1;
      coef_we = 1'b0;
   endtask

   // Send one sample to unit sel, return its result and check latency.
   task automatic send(input logic signed [7:0] x, input bit sel, input int taps,
                       output int y);
      int  lat;
      bit  got;
      for (int i = 0; i < 100 && !rdy(sel); i++) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b1; x_in = x;
      @(posedge clk); #1;
      in_valid = 1'b0;
      got = 1'b0; lat = 0; y = 0;
      for (int n = 1; n <= 40 && !got; n++) begin
         @(posedge clk); #1;
         if (ov(sel)) begin got = 1'b1; lat = n; y = yv(sel); end
      end
      chk("latency", lat, taps);
      if (got) begin
         @(posedge clk); #1;
         chk("ov_pulse", int'(ov(sel)), 0);
      end
   endtask

   initial begin
      int y, y1, y2, n1, n2, acc2, seen;
      bit pre;

      va[0] = '{1, 1, 1};   va[1] = '{0, 2, 2};   va[2] = '{0, 3, 3};
      va[3] = '{0, 4, 4};   va[4] = '{0, 0, 0};
      va[5] = '{1, 1, 1};   va[6] = '{2, 4, 4};   va[7] = '{3, 10, 10};
      va[8] = '{4, 20, 20};
      // h = 127 on all five taps, 8-bit output: wrap vs saturate.
      vb[0] = '{127, 1, 127};    vb[1] = '{127, 2, 127};    vb[2] = '{127, 3, 127};
      vb[3] = '{127, 4, 127};    vb[4] = '{127, 5, 127};
      vb[5] = '{-128, -124, 127}; vb[6] = '{-128, 3, 127};  vb[7] = '{-128, -126, -128};
      vb[8] = '{-128, 1, -128};  vb[9] = '{-128, -128, -128};

      x_in = '0; coef_addr = '0; coef_wdata = '0;
      do_reset();
      chk("rst_y_a", int'(y_a), 0);
      chk("rst_ov_a", int'(ov_a), 0);
      chk("rst_rdy_a", int'(rdy_a), 1);
      chk("rst_err_a", int'(err_a), 0);
      chk("rst_y_b", int'(y_b), 0);

      // Impulse then ramp with default coefficients.
      for (int i = 0; i < 9; i++) begin
         send(va[i].x, 1'b0, 4, y);
         chk($sformatf("vecA[%0d]", i), y, va[i].y_wrap);
      end

      // All-ones coefficients, history kept: line 0,4,3,2 -> 9.
      for (int i = 0; i < 4; i++) wr(i, 1);
      chk("wr_ok_err", int'(err_a), 0);
      send(8'sd0, 1'b0, 4, y);
      chk("h_ones", y, 9);

      // Write during MAC is dropped and flagged.
      in_valid = 1'b1; x_in = 8'sd0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wr(0, 9);
      chk("busy_err", int'(err_a), 1);
      @(posedge clk); #1;
      chk("busy_err_pulse", int'(err_a), 0);
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         if (ov_a) begin seen = 1; y = int'(y_a); end
         else begin @(posedge clk); #1; end
      end
      chk("busy_y", seen ? y : -9999, 7);
      send(8'sd2, 1'b0, 4, y);
      chk("h0_kept", y, 6);

      // Sample held through MAC is taken only when idle again.
      in_valid = 1'b1; x_in = 8'sd1;
      @(posedge clk); #1;
      x_in = 8'sd3;
      n1 = 0; n2 = 0; acc2 = 0; y1 = 0; y2 = 0;
      for (int n = 1; n <= 30 && n2 == 0; n++) begin
         pre = rdy_a;
         @(posedge clk); #1;
         if (pre && in_valid) begin in_valid = 1'b0; acc2 = n; end
         if (ov_a) begin
            if (n1 == 0) begin n1 = n; y1 = int'(y_a); end
            else begin n2 = n; y2 = int'(y_a); end
         end
      end
      in_valid = 1'b0;
      chk("hold_first_lat", n1, 4);
      chk("hold_first_y", y1, 3);
      chk("hold_accept_at", acc2, 5);
      chk("hold_second_lat", n2, 9);
      chk("hold_second_y", y2, 6);

      // Unit B: bad index, back-to-back writes, overflow behaviour.
      do_reset();
      wr(5, 50);
      chk("bad_addr_err", int'(err_b), 1);
      coef_we = 1'b1; coef_wdata = 8'sd127;
      for (int a = 0; a < 5; a++) begin
         coef_addr = 3'(a);
         @(posedge clk); #1;
         chk($sformatf("b2b_err[%0d]", a), int'(err_b), 0);
      end
      coef_we = 1'b0;
      for (int i = 0; i < 10; i++) begin
         send(vb[i].x, 1'b1, 5, y);
`ifdef FIR_SAT_EN
         chk($sformatf("vecB[%0d]", i), y, vb[i].y_sat);
`else
         chk($sformatf("vecB[%0d]", i), y, vb[i].y_wrap);
`endif
      end

      // Reset in the middle of a computation.
      do_reset();
      wr(0, 7);
      in_valid = 1'b1; x_in = 8'sd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_rdy", int'(rdy_a), 1);
      seen = 0;
      for (int n = 0; n < 8; n++) begin
         if (ov_a) seen = 1;
         @(posedge clk); #1;
      end
      chk("abort_no_ov", seen, 0);
      send(8'sd5, 1'b0, 4, y);
      chk("abort_then_y", y, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
